ppr_compress42_acc: RTL and testbench
=====================================

Name: ppr_compress42_acc

Overview:
- Parametrised, pipelined successor to the single-bit 4:2 compressor cell used in partial-product reduction (PPR).
- Takes four W-bit operands per beat and reduces them through two rows of 4:2 compressors.
- Keeps a running carry-save accumulator across a group of beats, then resolves it with a final carry-propagate adder (CPA).
- Used as the multi-operand reduction/accumulate stage behind the PPR array in the multiplier datapath.

Parameters:
- W, 8, operand width in bits.
- ACC_W, 16, accumulator and result width in bits (ACC_W >= W+2).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_last  in  1  final beat of the current accumulation group.
- acc_mode  in  1  1 = accumulate across beats until in_last; 0 = every beat is a complete group.
- i1, i2, i3, i4  in  W each  operands, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  group sum modulo 2^ACC_W.
- out_ovf  out  1  true group sum >= 2^ACC_W.

Behaviour:
- Reset (async assert, sync release): all pipeline registers, the accumulator (acc_s, acc_c), overflow sticky bits and valid bits clear to 0; out_sum=0, out_ovf=0, out_valid=0.
- Global stall: advance = !out_valid | out_ready; in_ready = advance. No register changes when advance=0. The output holds stable while out_valid=1 and out_ready=0.
- Beat accepted when in_valid & in_ready. Effective last: eff_last = in_last | !acc_mode.
- Stage A (capture cycle):
  - Zero-extend i1..i4 to ACC_W.
  - Row 1 of ACC_W 4:2 compressors, with the intra-row carry chain LSB-to-MSB (cin of bit 0 = 0), produces s1 and c1. c1 is shifted left by 1.
  - Register s1, c1, eff_last, a valid bit, and ovfA. ovfA = OR of bits dropped at the MSB (top compressor Cout, top C).
- Stage B, on a valid stage-A entry:
  - Row 2 compresses (s1, c1, acc_s, acc_c) into (ns, nc) the same way.
  - ovf_acc <= ovf_acc | ovfA | dropped bits of row 2.
  - If eff_last: load the CPA register with (ns, nc, merged ovf), set its valid, and clear acc_s, acc_c and ovf_acc to 0 in the same cycle.
  - Otherwise: acc_s <= ns, acc_c <= nc.
- Stage C: out_sum <= ns + nc (ACC_W bits); out_ovf <= merged ovf | CPA carry-out; out_valid <= 1.
  - out_valid clears on handshake (out_valid & out_ready) unless a new result loads in the same cycle.
- Latency: the result for a group appears with out_valid=1 exactly 3 cycles after the eff_last beat is accepted, when not stalled. Throughput is 1 beat per cycle.
- Overflow: all operands are nonnegative, so any dropped MSB carry, or the final carry-out, implies overflow. out_sum is always the exact sum modulo 2^ACC_W.
- Back-to-back groups: a new group's first beat may be accepted in the cycle after the previous eff_last beat. Accumulator clear and load never collide because clearing happens in stage B together with the last-beat update.
- acc_mode is sampled per beat. A beat with acc_mode=0 in the middle of a group terminates that group, including the beat itself.
- in_valid=0 beats insert bubbles. Bubbles do not modify the accumulator.
- reset_n asserted mid-group or mid-stall discards all partial state; no result is emitted for that group.

Test Plan:
- Reset: hold reset_n=0, toggle inputs -> out_valid=0, out_sum=0, out_ovf=0. After release, in_ready=1.
- Single mode (acc_mode=0), i1..i4 = 255,255,255,255 -> 3 cycles later out_valid=1, out_sum=1020, out_ovf=0.
- Accumulate: three beats of {1,2,3,4}, in_last on the third -> out_sum=30, exactly one out_valid pulse, 3 cycles after the third beat. An immediately following single beat {5,0,0,0} -> out_sum=5.
- Overflow (ACC_W=10): two beats of {255,255,255,255}, last on the second -> out_sum=1016 (2040 mod 1024), out_ovf=1. The next group {1,0,0,0} -> out_ovf=0, confirming the sticky flag clears.
- Backpressure: out_ready=0 while out_valid=1 -> in_ready=0 and out_sum held stable for 5 cycles while in_valid=1 stays pending. After out_ready=1, the pending beats produce correct sums; none are lost or duplicated.
- Mid-group reset: two beats of {10,10,10,10}, then pulse reset_n low -> no output. A following single-mode group {1,1,1,1} yields out_sum=4.

Source files
------------

// File: rtl/ppr_compress42_acc.sv
// Pipelined two-row 4:2 compressor reduction with a carry-save group accumulator
// and a final carry-propagate adder; one beat per cycle under a global stall.
module ppr_compress42_acc #(
  parameter int W     = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             acc_mode,
  input  logic [W-1:0]     i1,
  input  logic [W-1:0]     i2,
  input  logic [W-1:0]     i3,
  input  logic [W-1:0]     i4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef struct packed {
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] c;
    logic             ovf;
  } row_t;

  // One row of 4:2 compressors; cout ripples to the next bit's cin, the c output
  // carries weight 2, and anything leaving the MSB is reported as ovf.
  function automatic row_t compress_row(input logic [ACC_W-1:0] x1,
                                        input logic [ACC_W-1:0] x2,
                                        input logic [ACC_W-1:0] x3,
                                        input logic [ACC_W-1:0] x4);
    row_t             r;
    logic [ACC_W-1:0] cv;
    logic             cin;
    logic             cout;
    logic             sa;
    r.s   = {ACC_W{1'b0}};
    cv    = {ACC_W{1'b0}};
    cin   = 1'b0;
    cout  = 1'b0;
    for (int i = 0; i < ACC_W; i++) begin
      sa     = x1[i] ^ x2[i] ^ x3[i];
      cout   = (x1[i] & x2[i]) | (x1[i] & x3[i]) | (x2[i] & x3[i]);
      r.s[i] = sa ^ x4[i] ^ cin;
      cv[i]  = (sa & x4[i]) | (sa & cin) | (x4[i] & cin);
      cin    = cout;
    end
    r.c   = {cv[ACC_W-2:0], 1'b0};
    r.ovf = cv[ACC_W-1] | cout;
    return r;
  endfunction

  logic             advance_s;
  logic             eff_last_s;
  logic [ACC_W-1:0] ext1_s, ext2_s, ext3_s, ext4_s;
  row_t             row1_s;
  row_t             row2_s;
  logic             merged_ovf_s;
  logic [ACC_W:0]   cpa_s;

  logic [ACC_W-1:0] a_s_q, a_s_d, a_c_q, a_c_d;
  logic             a_vld_q, a_vld_d, a_last_q, a_last_d, a_ovf_q, a_ovf_d;
  logic [ACC_W-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0] b_s_q, b_s_d, b_c_q, b_c_d;
  logic             b_vld_q, b_vld_d, b_ovf_q, b_ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d, out_vld_q, out_vld_d;

  assign advance_s    = ~out_vld_q | out_ready;
  assign in_ready     = advance_s;
  assign eff_last_s   = in_last | ~acc_mode;

  assign ext1_s       = {{(ACC_W-W){1'b0}}, i1};
  assign ext2_s       = {{(ACC_W-W){1'b0}}, i2};
  assign ext3_s       = {{(ACC_W-W){1'b0}}, i3};
  assign ext4_s       = {{(ACC_W-W){1'b0}}, i4};
  assign row1_s       = compress_row(ext1_s, ext2_s, ext3_s, ext4_s);
  assign row2_s       = compress_row(a_s_q, a_c_q, acc_s_q, acc_c_q);
  assign merged_ovf_s = ovf_acc_q | a_ovf_q | row2_s.ovf;
  assign cpa_s        = {1'b0, b_s_q} + {1'b0, b_c_q};

  assign out_valid    = out_vld_q;
  assign out_sum      = out_sum_q;
  assign out_ovf      = out_ovf_q;

  // Next-state for all three stages; nothing moves while the output is stalled.
  always_comb begin
    a_s_d     = a_s_q;
    a_c_d     = a_c_q;
    a_vld_d   = a_vld_q;
    a_last_d  = a_last_q;
    a_ovf_d   = a_ovf_q;
    acc_s_d   = acc_s_q;
    acc_c_d   = acc_c_q;
    ovf_acc_d = ovf_acc_q;
    b_s_d     = b_s_q;
    b_c_d     = b_c_q;
    b_vld_d   = b_vld_q;
    b_ovf_d   = b_ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    out_vld_d = out_vld_q;
    if (advance_s) begin
      // Stage A data loads every cycle; only the valid bit gives it meaning.
      a_vld_d  = in_valid;
      a_s_d    = row1_s.s;
      a_c_d    = row1_s.c;
      a_last_d = eff_last_s;
      a_ovf_d  = row1_s.ovf;
      if (a_vld_q) begin
        if (a_last_q) begin
          b_s_d     = row2_s.s;
          b_c_d     = row2_s.c;
          b_ovf_d   = merged_ovf_s;
          b_vld_d   = 1'b1;
          acc_s_d   = {ACC_W{1'b0}};
          acc_c_d   = {ACC_W{1'b0}};
          ovf_acc_d = 1'b0;
        end else begin
          acc_s_d   = row2_s.s;
          acc_c_d   = row2_s.c;
          ovf_acc_d = merged_ovf_s;
          b_vld_d   = 1'b0;
        end
      end else begin
        b_vld_d = 1'b0;
      end
      if (b_vld_q) begin
        out_sum_d = cpa_s[ACC_W-1:0];
        out_ovf_d = b_ovf_q | cpa_s[ACC_W];
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      a_vld_d = a_vld_q;
    end
  end

  // Pipeline, accumulator and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_s_q     <= {ACC_W{1'b0}};
      a_c_q     <= {ACC_W{1'b0}};
      a_vld_q   <= 1'b0;
      a_last_q  <= 1'b0;
      a_ovf_q   <= 1'b0;
      acc_s_q   <= {ACC_W{1'b0}};
      acc_c_q   <= {ACC_W{1'b0}};
      ovf_acc_q <= 1'b0;
      b_s_q     <= {ACC_W{1'b0}};
      b_c_q     <= {ACC_W{1'b0}};
      b_vld_q   <= 1'b0;
      b_ovf_q   <= 1'b0;
      out_sum_q <= {ACC_W{1'b0}};
      out_ovf_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      a_s_q     <= a_s_d;
      a_c_q     <= a_c_d;
      a_vld_q   <= a_vld_d;
      a_last_q  <= a_last_d;
      a_ovf_q   <= a_ovf_d;
      acc_s_q   <= acc_s_d;
      acc_c_q   <= acc_c_d;
      ovf_acc_q <= ovf_acc_d;
      b_s_q     <= b_s_d;
      b_c_q     <= b_c_d;
      b_vld_q   <= b_vld_d;
      b_ovf_q   <= b_ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_ppr_compress42_acc.sv
// Scoreboard bench for ppr_compress42_acc (ACC_W=10 so overflow is reachable):
// stimulus pushes expected group results, a negedge monitor pops on each handshake.
module tb_ppr_compress42_acc;
  localparam int W     = 8;
  localparam int ACC_W = 10;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_last = 1'b0;
  logic             acc_mode = 1'b0;
  logic [W-1:0]     i1 = '0, i2 = '0, i3 = '0, i4 = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  ppr_compress42_acc #(.W(W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .acc_mode(acc_mode), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int sum;
    int ovf;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, push the expected result if it ends a group.
  task automatic send(input int a, input int b, input int c, input int d,
                      input bit last, input bit mode, input bit push,
                      input int esum, input int eovf, input bit chk_lat);
    bit ok;
    i1 = W'(a); i2 = W'(b); i3 = W'(c); i4 = W'(d);
    in_last = last; acc_mode = mode; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: beat %0d,%0d,%0d,%0d never accepted", a, b, c, d);
    end else if (push) begin
      sb.push_back('{esum, eovf, chk_lat ? cyc + 3 : -1});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got sum %0d ovf %0d, expected no result", out_sum, out_ovf);
      end else begin
        mon_e = sb.pop_front();
        check("out_sum", int'(out_sum), mon_e.sum);
        check("out_ovf", int'(out_ovf), mon_e.ovf);
        if (mon_e.cyc >= 0) check("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with toggling inputs
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_last = 1'b1; acc_mode = 1'b0;
      i1 = W'($urandom); i2 = W'($urandom); i3 = W'($urandom); i4 = W'($urandom);
      @(negedge clk);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_sum", int'(out_sum), 0);
      check("reset_out_ovf", int'(out_ovf), 0);
    end
    in_valid = 1'b0;
    idle(1);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", int'(in_ready), 1);
    idle(1);

    // Single mode: 4 x 255
    send(255, 255, 255, 255, 1'b0, 1'b0, 1'b1, 1020, 0, 1'b1);
    idle(4);

    // Accumulate three beats of {1,2,3,4}, then an immediate single beat
    send(1, 2, 3, 4, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    send(1, 2, 3, 4, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    send(1, 2, 3, 4, 1'b1, 1'b1, 1'b1, 30, 0, 1'b1);
    send(5, 0, 0, 0, 1'b0, 1'b0, 1'b1, 5, 0, 1'b1);
    idle(4);

    // Overflow: 2040 mod 1024, then the sticky flag must be gone
    send(255, 255, 255, 255, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    send(255, 255, 255, 255, 1'b1, 1'b1, 1'b1, 1016, 1, 1'b1);
    send(1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1);
    idle(4);

    // acc_mode=0 mid-group terminates the group including that beat
    send(1, 1, 1, 1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    send(2, 2, 2, 2, 1'b0, 1'b0, 1'b1, 12, 0, 1'b1);
    // Bubbles inside a group leave the accumulator alone
    send(1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(3);
    send(0, 1, 0, 0, 1'b1, 1'b1, 1'b1, 2, 0, 1'b1);
    idle(4);

    // Backpressure: output held, input stalled, nothing lost or duplicated
    out_ready = 1'b0;
    fork
      begin
        send(1, 1, 1, 1, 1'b0, 1'b0, 1'b1, 4, 0, 1'b0);
        send(2, 0, 0, 0, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0);
        send(3, 0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 0, 1'b0);
        send(4, 4, 4, 4, 1'b0, 1'b0, 1'b1, 16, 0, 1'b0);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          n_checks++;
          n_fail++;
          $display("FAIL stall_wait: out_valid never rose under backpressure");
        end
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check("stall_in_ready", int'(in_ready), 0);
          check("stall_out_valid", int'(out_valid), 1);
          check("stall_out_sum", int'(out_sum), 4);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(8);

    // Mid-group reset discards the partial group
    send(10, 10, 10, 10, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    send(10, 10, 10, 10, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_out_valid", int'(out_valid), 0);
    idle(1);
    send(1, 1, 1, 1, 1'b0, 1'b0, 1'b1, 4, 0, 1'b1);

    idle(10);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
